// File: rtl/wisc_pkg.sv
// Shared types and constants for the 16-bit pipelined CPU.
// Holds the writeback state encoding, the hard-wired zero register and datapath defaults.
package wisc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 4;

  localparam logic [3:0] REG_ZERO = 4'd0;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WRITE    = 2'd1,
    WB_WAIT_MEM = 2'd2
  } wb_state_e;

  // LHB replaces the high byte, LLB the low byte, of the destination's current value.
  function automatic logic [15:0] byte_merge(input logic high, input logic [7:0] imm8,
                                             input logic [15:0] oldval);
    return high ? {imm8, oldval[7:0]} : {oldval[15:8], imm8};
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-writeback handshake bundle: retiring instruction fields, load data and back-pressure.
// The MEM stage is the master; wb_stage is the slave and returns wb_busy.
interface wb_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              m_valid;
  logic [REG_AW-1:0] m_dst;
  logic              m_regwrite;
  logic              m_memtoreg;
  logic              m_pcsave;
  logic              m_ldbyte;
  logic              m_ldhigh;
  logic [7:0]        m_imm8;
  logic [DATA_W-1:0] m_oldval;
  logic [DATA_W-1:0] m_alu;
  logic [DATA_W-1:0] m_pcs;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;
  logic              wb_busy;

  modport master (
    output m_valid, m_dst, m_regwrite, m_memtoreg, m_pcsave, m_ldbyte, m_ldhigh,
           m_imm8, m_oldval, m_alu, m_pcs, mem_rdata, mem_rdy,
    input  wb_busy
  );

  modport slave (
    input  m_valid, m_dst, m_regwrite, m_memtoreg, m_pcsave, m_ldbyte, m_ldhigh,
           m_imm8, m_oldval, m_alu, m_pcs, mem_rdata, mem_rdy,
    output wb_busy
  );
endinterface

// File: rtl/wb_bypass.sv
// One register-file read port's write-before-read bypass: forwards the in-flight write.
// Only built when WB_BYPASS_EN is defined.
`ifdef WB_BYPASS_EN
module wb_bypass #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_idx,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] rd_data
);
  assign rd_data = (wr_en && (wr_idx == rd_idx)) ? wr_data : rf_data;
endmodule
`endif

// File: rtl/wb_stage.sv
// Writeback stage: latches one retiring instruction, selects its result and drives the RF write port.
// Define WB_BYPASS_EN to forward the current write onto decode's read data.
module wb_stage
  import wisc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  wb_stage_if.slave         mem,
  output logic [REG_AW-1:0] DstReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  input  logic [REG_AW-1:0] SrcReg1,
  input  logic [REG_AW-1:0] SrcReg2,
  input  logic [DATA_W-1:0] RfData1,
  input  logic [DATA_W-1:0] RfData2,
  output logic [DATA_W-1:0] RegData1,
  output logic [DATA_W-1:0] RegData2
);

  wb_state_e         state;
  logic [REG_AW-1:0] dst_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;
  logic              regwrite_q;
  logic              busy_q;

  logic              eff_we;
  logic              need_wait;
  logic [DATA_W-1:0] sel_data;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    sel_data  = mem.m_alu;
    eff_we    = mem.m_regwrite && (mem.m_dst != REG_AW'(REG_ZERO));
    need_wait = mem.m_memtoreg && !mem.m_ldbyte && !mem.m_pcsave && !mem.mem_rdy;
    if (mem.m_ldbyte)        sel_data = byte_merge(mem.m_ldhigh, mem.m_imm8, mem.m_oldval);
    else if (mem.m_pcsave)   sel_data = mem.m_pcs;
    else if (mem.m_memtoreg) sel_data = mem.mem_rdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the result latch is reset too, because DstReg/WriteData are visible outputs with defined reset values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WB_IDLE;
      dst_q      <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      regwrite_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        WB_IDLE, WB_WRITE: begin
          if (mem.m_valid) begin
            dst_q  <= mem.m_dst;
            data_q <= sel_data;
            we_q   <= eff_we;
            if (need_wait) begin
              state      <= WB_WAIT_MEM;
              regwrite_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              state      <= WB_WRITE;
              regwrite_q <= eff_we;
              busy_q     <= 1'b0;
            end
          end else begin
            state      <= WB_IDLE;
            regwrite_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        WB_WAIT_MEM: begin
          // Upstream holds m_* stable here; only the load data is still to be latched.
          if (mem.mem_rdy) begin
            data_q     <= mem.mem_rdata;
            state      <= WB_WRITE;
            regwrite_q <= we_q;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state      <= WB_IDLE;
          regwrite_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign DstReg      = dst_q;
  assign WriteData   = data_q;
  assign RegWrite    = regwrite_q;
  assign mem.wb_busy = busy_q;

`ifdef WB_BYPASS_EN
  wb_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass1 (
    .wr_en   (regwrite_q),
    .wr_idx  (dst_q),
    .wr_data (data_q),
    .rd_idx  (SrcReg1),
    .rf_data (RfData1),
    .rd_data (RegData1)
  );

  wb_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass2 (
    .wr_en   (regwrite_q),
    .wr_idx  (dst_q),
    .wr_data (data_q),
    .rd_idx  (SrcReg2),
    .rf_data (RfData2),
    .rd_data (RegData2)
  );
`else
  assign RegData1 = RfData1;
  assign RegData2 = RfData2;

  // Read indices only matter to the bypass; keep them on the port list regardless.
  logic unused_src;
  assign unused_src = ^{SrcReg1, SrcReg2};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed instructions push expected writes, a monitor checks them.
// Bypass expectations follow WB_BYPASS_EN the same way the design build does.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic [3:0]  DstReg;
  logic [15:0] WriteData;
  logic        RegWrite;
  logic [3:0]  SrcReg1, SrcReg2;
  logic [15:0] RfData1, RfData2;
  logic [15:0] RegData1, RegData2;

  wb_stage_if #(.DATA_W(16), .REG_AW(4)) bus ();

  wb_stage #(.DATA_W(16), .REG_AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (bus),
    .DstReg    (DstReg),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .SrcReg1   (SrcReg1),
    .SrcReg2   (SrcReg2),
    .RfData1   (RfData1),
    .RfData2   (RfData2),
    .RegData1  (RegData1),
    .RegData2  (RegData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  dst;
    logic [15:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && RegWrite === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got DstReg=%0d WriteData=%h, expected no write", DstReg, WriteData);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_dst", 32'(DstReg), 32'(e.dst));
        check("wr_data", 32'(WriteData), 32'(e.data));
      end
    end
  end

  task automatic drive(input logic [3:0] dst, input logic rw, input logic mtr, input logic pcs,
                       input logic ldb, input logic ldh, input logic [7:0] imm,
                       input logic [15:0] old, input logic [15:0] alu, input logic [15:0] pcv,
                       input logic [15:0] rd, input logic rdy);
    bus.m_valid    = 1'b1;
    bus.m_dst      = dst;
    bus.m_regwrite = rw;
    bus.m_memtoreg = mtr;
    bus.m_pcsave   = pcs;
    bus.m_ldbyte   = ldb;
    bus.m_ldhigh   = ldh;
    bus.m_imm8     = imm;
    bus.m_oldval   = old;
    bus.m_alu      = alu;
    bus.m_pcs      = pcv;
    bus.mem_rdata  = rd;
    bus.mem_rdy    = rdy;
  endtask

  task automatic expect_wr(input logic [3:0] dst, input logic [15:0] data);
    wr_t e;
    e.dst  = dst;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m_valid = 1'b0;
    bus.mem_rdy = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    SrcReg1 = 4'd0; SrcReg2 = 4'd0; RfData1 = 16'h0; RfData2 = 16'h0;
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    bus.m_valid = 1'b0;
    #12;
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_dstreg", 32'(DstReg), 32'd0);
    check("rst_writedata", 32'(WriteData), 32'd0);
    check("rst_busy", 32'(bus.wb_busy), 32'd0);
    rst = 1'b0;
    step();

    // Plain ALU result to R3, then back to IDLE.
    drive(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0);
    expect_wr(4'd3, 16'h1234);
    step();
    check("alu_regwrite", 32'(RegWrite), 32'd1);
    idle();
    check("idle_regwrite", 32'(RegWrite), 32'd0);
    check("idle_busy", 32'(bus.wb_busy), 32'd0);

    // Back-to-back: LLB (memtoreg set, data not ready: byte op must not stall), LHB over PCS, PCS over load.
    drive(4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 16'hABCD, 16'h1111, 16'h2222, 16'h3333, 1'b0);
    expect_wr(4'd1, 16'hAB5A);
    step();
    check("llb_busy", 32'(bus.wb_busy), 32'd0);
    drive(4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 16'hABCD, 16'h1111, 16'h2222, 16'h3333, 1'b0);
    expect_wr(4'd2, 16'h5ACD);
    step();
    drive(4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 16'hFFFF, 16'h0042, 16'h3333, 1'b0);
    expect_wr(4'd15, 16'h0042);
    step();
    check("pcs_busy", 32'(bus.wb_busy), 32'd0);
    // Load with data already ready, then writes that must not reach the register file.
    drive(4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h1111, 16'h0000, 16'hCAFE, 1'b1);
    expect_wr(4'd4, 16'hCAFE);
    step();
    check("fastload_busy", 32'(bus.wb_busy), 32'd0);
    drive(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h9999, 16'h0000, 16'h0000, 1'b0);
    step();
    check("r0_regwrite", 32'(RegWrite), 32'd0);
    drive(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h6666, 16'h0000, 16'h0000, 1'b0);
    step();
    check("nowrite_regwrite", 32'(RegWrite), 32'd0);
    idle();

    // Late load to R8: three busy cycles, then BEEF, then the held ALU op to R9.
    drive(4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h1111, 16'h0000, 16'hDEAD, 1'b0);
    expect_wr(4'd8, 16'hBEEF);
    step();
    check("late_busy0", 32'(bus.wb_busy), 32'd1);
    drive(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0909, 16'h0000, 16'hDEAD, 1'b0);
    expect_wr(4'd9, 16'h0909);
    step();
    check("late_busy1", 32'(bus.wb_busy), 32'd1);
    check("late_nowrite", 32'(RegWrite), 32'd0);
    step();
    check("late_busy2", 32'(bus.wb_busy), 32'd1);
    bus.mem_rdata = 16'hBEEF;
    bus.mem_rdy   = 1'b1;
    step();
    check("late_busy_clear", 32'(bus.wb_busy), 32'd0);
    check("late_regwrite", 32'(RegWrite), 32'd1);
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = 16'h0000;
    step();
    check("held_dst", 32'(DstReg), 32'd9);
    check("held_regwrite", 32'(RegWrite), 32'd1);
    idle();

    // Write to R5 while decode reads R5 and R6.
    SrcReg1 = 4'd5; RfData1 = 16'h0000;
    SrcReg2 = 4'd6; RfData2 = 16'h1111;
    drive(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h7777, 16'h0000, 16'h0000, 1'b0);
    expect_wr(4'd5, 16'h7777);
    step();
`ifdef WB_BYPASS_EN
    check("bypass_regdata1", 32'(RegData1), 32'h7777);
`else
    check("bypass_regdata1", 32'(RegData1), 32'h0000);
`endif
    check("bypass_regdata2", 32'(RegData2), 32'h1111);
    idle();
    check("nobypass_idle", 32'(RegData1), 32'h0000);

    // Reset during WAIT_MEM abandons the load; a later mem_rdy pulse writes nothing.
    drive(4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h1111, 16'h0000, 16'hAAAA, 1'b0);
    step();
    check("abort_busy", 32'(bus.wb_busy), 32'd1);
    bus.m_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("abort_busy_rst", 32'(bus.wb_busy), 32'd0);
    check("abort_dst_rst", 32'(DstReg), 32'd0);
    check("abort_data_rst", 32'(WriteData), 32'd0);
    step();
    rst = 1'b0;
    bus.mem_rdata = 16'h1357;
    bus.mem_rdy   = 1'b1;
    step();
    bus.mem_rdy = 1'b0;
    check("abort_regwrite", 32'(RegWrite), 32'd0);
    check("abort_busy_after", 32'(bus.wb_busy), 32'd0);
    step();
    check("abort_regwrite2", 32'(RegWrite), 32'd0);
    step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage for the 16-bit pipelined CPU: the write-side counterpart of `decode`, driving the register-file write port (`DstReg`, `WriteData`, `RegWrite`) that `decode` consumes. Latches one retiring instruction from the MEM stage and selects its result: ALU, load data, PC+2 for PCS, or LLB/LHB byte merge. Stretches for slow load data with a busy back-pressure signal. Optionally provides write-before-read bypass for decode's register reads.

## Interface
Parameters:
- `DATA_W`, 16, datapath width
- `REG_AW`, 4, register index width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `m_valid`  in  1  MEM stage presents an instruction
- `m_dst`  in  4  destination register
- `m_regwrite`  in  1  instruction writes a register
- `m_memtoreg`  in  1  result is load data
- `m_pcsave`  in  1  result is `m_pcs` (PCS)
- `m_ldbyte`  in  1  LLB/LHB
- `m_ldhigh`  in  1  1 = LHB, 0 = LLB
- `m_imm8`  in  8  byte immediate
- `m_oldval`  in  16  current value of the destination register
- `m_alu`  in  16  ALU result
- `m_pcs`  in  16  PC+2
- `mem_rdata`  in  16  load data
- `mem_rdy`  in  1  `mem_rdata` valid this cycle
- `wb_busy`  out  1  waiting on load data; upstream holds `m_*` stable
- `DstReg`  out  4  register-file write index
- `WriteData`  out  16  register-file write data
- `RegWrite`  out  1  register-file write enable
- `SrcReg1`, `SrcReg2`  in  4  decode read indices
- `RfData1`, `RfData2`  in  16  raw register-file read data
- `RegData1`, `RegData2`  out  16  read data after the optional bypass

## Operation
- States: IDLE (nothing latched), WRITE (result latched, write in progress), WAIT_MEM (load latched, data outstanding).
- Capture happens in IDLE or WRITE when `m_valid`=1:
  - Latch `m_dst`.
  - Latch the effective write enable = `m_regwrite` & (`m_dst`≠0). R0 is never written.
  - Data select, in priority order: `m_ldbyte` → `{m_imm8, m_oldval[7:0]}` (LHB) or `{m_oldval[15:8], m_imm8}` (LLB); `m_pcsave` → `m_pcs`; `m_memtoreg` → `mem_rdata`; otherwise `m_alu`.
  - Next state: WAIT_MEM if `m_memtoreg` & ~`m_ldbyte` & ~`m_pcsave` & ~`mem_rdy`; else WRITE.
- In IDLE or WRITE with `m_valid`=0, go to IDLE.
- WAIT_MEM:
  - `m_valid` is ignored.
  - On `mem_rdy`=1, latch `mem_rdata` and go to WRITE.
  - Otherwise stay in WAIT_MEM, with no timeout.
- Outputs:
  - `RegWrite` = (state==WRITE) & latched write enable.
  - `DstReg` and `WriteData` come straight from the latch.
  - `wb_busy` = (state==WAIT_MEM).

## Timing
- Reset values: state IDLE; `RegWrite`=0, `DstReg`=0, `WriteData`=0, `wb_busy`=0.
- Reset asserted during WAIT_MEM abandons the load; nothing is written.
- Non-load, or load with `mem_rdy` high at capture: captured at edge N, `RegWrite` high for cycle N..N+1, register file writes at edge N+1.
- Back-to-back instructions retire one per cycle.
- Load with late data: `wb_busy` high from edge N until the edge that samples `mem_rdy`=1 (edge M). WRITE runs from M to M+1. The next instruction is captured at M+1.
- `wb_busy` is registered and has no combinational path from any input.
- `RegData*` is a combinational function of its inputs and the latched state.

## Configuration
- `WB_BYPASS_EN` defined:
  - `RegDataN` = `WriteData` when `RegWrite` & (`DstReg`==`SrcRegN`).
  - Otherwise `RegDataN` = `RfDataN`.
  - Gives decode same-cycle write-before-read.
- Undefined: `RegDataN` = `RfDataN` unconditionally. Ports are unchanged.

## Structure
- Shared package `wisc_pkg`:
  - WB state enum (IDLE/WRITE/WAIT_MEM)
  - `REG_ZERO` = 4'd0
  - `DATA_W`/`REG_AW` defaults
- One sub-module, `wb_bypass`: the two index comparators and muxes, instantiated for both read ports, compiled under `WB_BYPASS_EN`.

## Test plan
- Reset, then `m_valid`=1, ALU op, `m_dst`=3, `m_alu`=16'h1234 → next cycle `RegWrite`=1, `DstReg`=3, `WriteData`=16'h1234; IDLE afterwards.
- LLB with `m_oldval`=16'hABCD, `m_imm8`=8'h5A → `WriteData`=16'hAB5A. LHB with the same inputs → `WriteData`=16'h5ACD.
- Load with `mem_rdy`=0 for 3 cycles, then `mem_rdata`=16'hBEEF with `mem_rdy`=1:
  - `wb_busy` high for exactly 3 cycles, then 1 cycle of `RegWrite` with 16'hBEEF.
  - The held next instruction retires the following cycle.
- `m_regwrite`=1, `m_dst`=0 → `RegWrite` stays 0. PCS with `m_pcs`=16'h0042 to R15 → `WriteData`=16'h0042.
- Bypass built, `RegWrite` to R5 = 16'h7777, `SrcReg1`=5, `RfData1`=16'h0000 → `RegData1`=16'h7777. Bypass not built → `RegData1`=16'h0000.
- Assert `rst` during WAIT_MEM → outputs return to 0, state IDLE; a later `mem_rdy` pulse causes no write.
